decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 38 +++
 rtl/decode_stage.sv | 140 ++++++++++++++
 tb/tb_decode_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle signals between the fetch side, the decode stage and its consumer.
// The slave modport is the decode stage's view of these signals; the master modport is the view of whatever drives it.
interface decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int RA_W = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     ir;
  logic [PC_W-1:0] pc;

  logic            out_valid;
  logic            out_ready;
  logic [6:0]      op;
  logic [RA_W-1:0] addr_d;
  logic [RA_W-1:0] addr_a;
  logic [RA_W-1:0] addr_b;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] offset_st;
  logic            y_sel;
  logic            write;
  logic            illegal;
  logic [PC_W-1:0] pc_out;

  modport master (
    output flush, in_valid, ir, pc, out_ready,
    input  in_ready, out_valid, op, addr_d, addr_a, addr_b,
           offset, offset_st, y_sel, write, illegal, pc_out
  );

  modport slave (
    input  flush, in_valid, ir, pc, out_ready,
    output in_ready, out_valid, op, addr_d, addr_a, addr_b,
           offset, offset_st, y_sel, write, illegal, pc_out
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes ir at acceptance and holds results in a 2-entry skid buffer.
// in_ready depends on registered state only, so out_ready never reaches upstream combinationally.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int RA_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic [6:0]      op;
    logic [RA_W-1:0] addr_d;
    logic [RA_W-1:0] addr_a;
    logic [RA_W-1:0] addr_b;
    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] offset_st;
    logic            y_sel;
    logic            write;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t  state_reg;
  logic    in_ready_reg;
  logic    out_valid_reg;
  bundle_t main_reg;
  bundle_t skid_reg;
  bundle_t dec_next;

  logic [14:0]     offset_raw;
  logic [14:0]     offset_st_raw;
  logic [XLEN-1:0] offset_ext;
  logic [XLEN-1:0] offset_st_ext;

  logic accept;
  logic consume;

  assign accept  = bus.in_valid & in_ready_reg;
  assign consume = out_valid_reg & bus.out_ready;

  assign offset_raw    = bus.ir[14:0];
  assign offset_st_raw = {bus.ir[24:20], bus.ir[9:0]};

  // Bit-wise sign extension of both 15-bit immediate forms up to XLEN.
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_sext
    if (gi < 15) begin : g_low
      assign offset_ext[gi]    = offset_raw[gi];
      assign offset_st_ext[gi] = offset_st_raw[gi];
    end else begin : g_high
      assign offset_ext[gi]    = offset_raw[14];
      assign offset_st_ext[gi] = offset_st_raw[14];
    end
  end

  always_comb begin
    dec_next           = '0;
    dec_next.op        = bus.ir[31:25];
    dec_next.addr_d    = RA_W'(bus.ir[24:20]);
    dec_next.addr_a    = RA_W'(bus.ir[19:15]);
    dec_next.addr_b    = RA_W'(bus.ir[14:10]);
    dec_next.offset    = offset_ext;
    dec_next.offset_st = offset_st_ext;
    // Only the register-register ALU group 0x10-0x13 takes operand B from the register file.
    dec_next.y_sel     = (bus.ir[31:27] != 5'b00100);
    dec_next.illegal   = (bus.ir[31:30] == 2'b11);
    dec_next.write     = (bus.ir[31:29] != 3'b011) && (bus.ir[31:30] != 2'b11);
    dec_next.pc        = bus.pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      main_reg      <= '0;
      skid_reg      <= '0;
    end else if (bus.flush) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            main_reg      <= dec_next;
            state_reg     <= ONE;
            out_valid_reg <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            skid_reg     <= dec_next;
            state_reg    <= TWO;
            in_ready_reg <= 1'b0;
          end else if (!accept && consume) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
          end else if (accept && consume) begin
            main_reg <= dec_next;
          end
        end
        TWO: begin
          if (consume) begin
            main_reg     <= skid_reg;
            state_reg    <= ONE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.op        = main_reg.op;
  assign bus.addr_d    = main_reg.addr_d;
  assign bus.addr_a    = main_reg.addr_a;
  assign bus.addr_b    = main_reg.addr_b;
  assign bus.offset    = main_reg.offset;
  assign bus.offset_st = main_reg.offset_st;
  assign bus.y_sel     = main_reg.y_sel;
  assign bus.write     = main_reg.write;
  assign bus.illegal   = main_reg.illegal;
  assign bus.pc_out    = main_reg.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage at XLEN=64, RA_W=6: directed cases plus a scoreboarded random stream.
module tb_decode_stage;
  localparam int XLEN = 64;
  localparam int PC_W = 32;
  localparam int RA_W = 6;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  decode_stage_if #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W)) bus ();

  decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .RA_W(RA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]      op;
    logic [RA_W-1:0] addr_d;
    logic [RA_W-1:0] addr_a;
    logic [RA_W-1:0] addr_b;
    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] offset_st;
    logic            y_sel;
    logic            write;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [PC_W-1:0] p);
    exp_t        e;
    logic [14:0] st;
    e.op      = w[31:25];
    e.addr_d  = {1'b0, w[24:20]};
    e.addr_a  = {1'b0, w[19:15]};
    e.addr_b  = {1'b0, w[14:10]};
    e.offset  = w[14] ? {49'h1_FFFF_FFFF_FFFF, w[14:0]} : {49'h0, w[14:0]};
    st        = {w[24:20], w[9:0]};
    e.offset_st = st[14] ? {49'h1_FFFF_FFFF_FFFF, st} : {49'h0, st};
    e.y_sel   = !(e.op >= 7'h10 && e.op <= 7'h13);
    e.illegal = (e.op >= 7'h60);
    e.write   = !(e.op >= 7'h30 && e.op <= 7'h3F) && !e.illegal;
    e.pc      = p;
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on consume; flush/reset discard everything held.
  always @(negedge clk) begin
    if (!rst_n || bus.flush) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("consume op=%h pc=%h", bus.op, bus.pc_out);
          check("sb_op", 64'(bus.op), 64'(e.op));
          check("sb_addr_d", 64'(bus.addr_d), 64'(e.addr_d));
          check("sb_addr_a", 64'(bus.addr_a), 64'(e.addr_a));
          check("sb_addr_b", 64'(bus.addr_b), 64'(e.addr_b));
          check("sb_offset", bus.offset, e.offset);
          check("sb_offset_st", bus.offset_st, e.offset_st);
          check("sb_y_sel", 64'(bus.y_sel), 64'(e.y_sel));
          check("sb_write", 64'(bus.write), 64'(e.write));
          check("sb_illegal", 64'(bus.illegal), 64'(e.illegal));
          check("sb_pc", 64'(bus.pc_out), 64'(e.pc));
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.ir, bus.pc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.ir = '0;
    bus.pc = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_op", 64'(bus.op), 64'd0);
    check("rst_offset", bus.offset, 64'd0);
    check("rst_pc_out", 64'(bus.pc_out), 64'd0);
    tick();
    rst_n = 1'b1;

    // Single decode
    bus.in_valid = 1'b1; bus.ir = 32'h2234_8405; bus.pc = 32'h100; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("single_valid", 64'(bus.out_valid), 64'd1);
    check("single_op", 64'(bus.op), 64'h11);
    check("single_addr_d", 64'(bus.addr_d), 64'd3);
    check("single_addr_a", 64'(bus.addr_a), 64'd9);
    check("single_addr_b", 64'(bus.addr_b), 64'd1);
    check("single_y_sel", 64'(bus.y_sel), 64'd0);
    check("single_write", 64'(bus.write), 64'd1);
    check("single_illegal", 64'(bus.illegal), 64'd0);
    check("single_offset", bus.offset, 64'h405);
    tick();

    // Sign extension
    bus.in_valid = 1'b1; bus.ir = 32'h6000_7FFF; bus.pc = 32'h104;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("sext_offset", bus.offset, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sext_offset_st", bus.offset_st, 64'h3FF);
    check("sext_y_sel", 64'(bus.y_sel), 64'd1);
    check("sext_write", 64'(bus.write), 64'd0);
    tick();

    // Illegal opcode
    bus.in_valid = 1'b1; bus.ir = 32'hFE00_0000; bus.pc = 32'h108;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("illegal_flag", 64'(bus.illegal), 64'd1);
    check("illegal_write", 64'(bus.write), 64'd0);
    tick();

    // Backpressure: fill both entries, hold, then drain in order
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.ir = 32'h2234_8405; bus.pc = 32'h200;
    tick();
    bus.ir = 32'h6000_7FFF; bus.pc = 32'h204;
    tick();
    bus.ir = 32'h0000_0001; bus.pc = 32'h208;
    @(negedge clk);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_op_a", 64'(bus.op), 64'h11);
    tick();
    @(negedge clk);
    check("bp_hold_op", 64'(bus.op), 64'h11);
    check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_a", 64'(bus.op), 64'h11);
    tick();
    @(negedge clk);
    check("bp_drain_b", 64'(bus.op), 64'h30);
    check("bp_drain_b_valid", 64'(bus.out_valid), 64'd1);
    tick();
    @(negedge clk);
    check("bp_empty", 64'(bus.out_valid), 64'd0);

    // Flush in TWO with a concurrent offer
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.ir = 32'h2000_0001; bus.pc = 32'h300;
    tick();
    bus.ir = 32'h2000_0002; bus.pc = 32'h304;
    tick();
    bus.ir = 32'h2000_0003; bus.pc = 32'h308; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("flush_no_ghost", 64'(bus.out_valid), 64'd0);
    end

    // Reset mid-stream while in ONE
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.ir = 32'h2234_8405; bus.pc = 32'h400;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid_one_valid", 64'(bus.out_valid), 64'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_op", 64'(bus.op), 64'd0);

    // Random streaming with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.ir        = $urandom;
      bus.pc        = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);
    check("drain_out_valid", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
